// File: rtl/display_pkg.sv
// ============================================================================
// Module   : display_pkg
// Purpose  : Shared state encoding and elaboration helpers for display_chain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR   = 3'd0,
        ST_CLRLOAD = 3'd1,
        ST_IDLE    = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_LOAD    = 3'd4
    } state_t;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic bit cfg_ok(input int nbits, input int nchains, input int clk_div);
        return (nbits >= 1) && (nchains >= 1) && (clk_div >= 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/display_pwm.sv
// ============================================================================
// Module   : display_pwm
// Purpose  : Free-running brightness counter; raw enable is high while the
//            counter is below the requested duty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_pwm #(
    parameter int BRIGHT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BRIGHT_W-1:0] i_brightness,
    output logic                o_pwm_on
);

    logic [BRIGHT_W-1:0] r_cnt_q;
    logic [BRIGHT_W-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q + BRIGHT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_pwm_on = (r_cnt_q < i_brightness);

endmodule

`default_nettype wire

// File: rtl/display_chain.sv
// ============================================================================
// Module   : display_chain
// Purpose  : Serialises NCHAINS LED images into daisy-chained shift/latch
//            parts with clear sequence, refresh handshake and PWM enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_chain #(
    parameter int NBITS        = 72,
    parameter int NCHAINS      = 1,
    parameter int CLK_DIV      = 4,
    parameter int MSB_FIRST    = 1,
    parameter int AUTO_REFRESH = 1,
    parameter int BRIGHT_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NCHAINS*NBITS-1:0]   display_bits,
    input  logic [BRIGHT_W-1:0]        brightness,
    input  logic                       update,
    output logic                       busy,
    output logic                       sclk,
    output logic [NCHAINS-1:0]         sdata,
    output logic                       sload,
    output logic                       sclr_n,
    output logic                       soe_n
);

    import display_pkg::*;

    localparam int c_DIV_W = clog2_min1(2 * CLK_DIV);
    localparam int c_BIT_W = clog2_min1(NBITS + 1);
    localparam int c_IDX_W = clog2_min1(NBITS);

    localparam logic [c_DIV_W-1:0] c_DIV_HALF = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_RISE = c_DIV_W'(CLK_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_FULL = c_DIV_W'(2 * CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(NBITS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_TOP  = c_IDX_W'(NBITS - 1);

    if (!cfg_ok(NBITS, NCHAINS, CLK_DIV)) begin : g_bad_cfg
        $error("display_chain: NBITS, NCHAINS and CLK_DIV must all be >= 1");
    end

    state_t                     r_state_q,   w_state_d;
    logic [c_DIV_W-1:0]         r_div_q,     w_div_d;
    logic [c_BIT_W-1:0]         r_bit_q,     w_bit_d;
    logic                       r_pending_q, w_pending_d;
    logic [NCHAINS*NBITS-1:0]   r_image_q,   w_image_d;

    logic                       w_trigger;
    logic                       w_pwm_on;
    logic [c_IDX_W-1:0]         w_bit_idx;

    assign w_trigger = update | r_pending_q |
                       ((AUTO_REFRESH != 0) && (display_bits != r_image_q));

    always_comb begin
        w_state_d   = r_state_q;
        w_div_d     = r_div_q + c_DIV_W'(1);
        w_bit_d     = r_bit_q;
        w_pending_d = r_pending_q;
        w_image_d   = r_image_q;

        case (r_state_q)
            ST_CLEAR: begin
                if (r_div_q == c_DIV_HALF) begin
                    w_state_d = ST_CLRLOAD;
                    w_div_d   = '0;
                end
            end
            ST_CLRLOAD: begin
                if (r_div_q == c_DIV_HALF) begin
                    w_state_d = ST_IDLE;
                    w_div_d   = '0;
                end
            end
            ST_IDLE: begin
                w_div_d = '0;
                if (w_trigger) begin
                    w_image_d   = display_bits;
                    w_pending_d = 1'b0;
                    w_bit_d     = '0;
                    w_state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_div_q == c_DIV_FULL) begin
                    w_div_d = '0;
                    if (r_bit_q == c_BIT_LAST) begin
                        w_state_d = ST_LOAD;
                    end else begin
                        w_bit_d = r_bit_q + c_BIT_W'(1);
                    end
                end
            end
            ST_LOAD: begin
                if (r_div_q == c_DIV_HALF) begin
                    w_state_d = ST_IDLE;
                    w_div_d   = '0;
                end
            end
            default: begin
                w_state_d = ST_CLEAR;
                w_div_d   = '0;
            end
        endcase

        // Requests outside IDLE collapse into a single follow-up frame.
        if ((r_state_q != ST_IDLE) && update) begin
            w_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= ST_CLEAR;
            r_div_q     <= '0;
            r_bit_q     <= '0;
            r_pending_q <= 1'b1;
            r_image_q   <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_div_q     <= w_div_d;
            r_bit_q     <= w_bit_d;
            r_pending_q <= w_pending_d;
            r_image_q   <= w_image_d;
        end
    end

    display_pwm #(
        .BRIGHT_W (BRIGHT_W)
    ) u_pwm (
        .clk          (clk),
        .rst          (rst),
        .i_brightness (brightness),
        .o_pwm_on     (w_pwm_on)
    );

    assign w_bit_idx = (MSB_FIRST != 0) ? (c_IDX_TOP - c_IDX_W'(r_bit_q))
                                        : c_IDX_W'(r_bit_q);

    for (genvar c = 0; c < NCHAINS; c++) begin : g_chain
        logic [NBITS-1:0] w_chain;
        assign w_chain  = r_image_q[c*NBITS +: NBITS];
        assign sdata[c] = (r_state_q == ST_SHIFT) & w_chain[w_bit_idx];
    end

    assign busy   = (r_state_q != ST_IDLE);
    assign sclk   = (r_state_q == ST_SHIFT) && (r_div_q >= c_DIV_RISE);
    assign sload  = (r_state_q == ST_CLRLOAD) || (r_state_q == ST_LOAD);
    assign sclr_n = (r_state_q != ST_CLEAR);
    assign soe_n  = ((r_state_q == ST_CLEAR) || (r_state_q == ST_CLRLOAD)) ? 1'b1 : ~w_pwm_on;

endmodule

`default_nettype wire

// File: tb/tb_display_chain.sv
// ============================================================================
// Module   : tb_display_chain
// Purpose  : Directed bench for display_chain: one MSB-first auto-refresh
//            instance and one LSB-first manual instance, 8 bits x 2 chains.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_chain;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [15:0] bits   [2];
    logic [7:0]  bright [2];
    logic        upd    [2];

    logic        busy_w   [2];
    logic        sclk_w   [2];
    logic [1:0]  sdata_w  [2];
    logic        sload_w  [2];
    logic        sclr_n_w [2];
    logic        soe_n_w  [2];

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state, one slot per instance.
    int          frame_cnt  [2] = '{0, 0};
    int          bitcnt     [2] = '{0, 0};
    int          busy_run   [2] = '{0, 0};
    int          busy_len   [2] = '{0, 0};
    logic        prev_sclk  [2] = '{1'b0, 1'b0};
    logic        prev_sload [2] = '{1'b0, 1'b0};
    logic [7:0]  sh0        [2];
    logic [7:0]  sh1        [2];
    logic [15:0] frames     [2][16];

    always #5 clk = ~clk;

    display_chain #(
        .NBITS(8), .NCHAINS(2), .CLK_DIV(2), .MSB_FIRST(1), .AUTO_REFRESH(1), .BRIGHT_W(8)
    ) u_dut_a (
        .clk(clk), .rst(rst), .display_bits(bits[0]), .brightness(bright[0]),
        .update(upd[0]), .busy(busy_w[0]), .sclk(sclk_w[0]), .sdata(sdata_w[0]),
        .sload(sload_w[0]), .sclr_n(sclr_n_w[0]), .soe_n(soe_n_w[0])
    );

    display_chain #(
        .NBITS(8), .NCHAINS(2), .CLK_DIV(2), .MSB_FIRST(0), .AUTO_REFRESH(0), .BRIGHT_W(8)
    ) u_dut_b (
        .clk(clk), .rst(rst), .display_bits(bits[1]), .brightness(bright[1]),
        .update(upd[1]), .busy(busy_w[1]), .sclk(sclk_w[1]), .sdata(sdata_w[1]),
        .sload(sload_w[1]), .sclr_n(sclr_n_w[1]), .soe_n(soe_n_w[1])
    );

    // Bits are captured on sclk rising; a frame is recorded on the latch strobe.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                bitcnt[d]     <= 0;
                prev_sclk[d]  <= 1'b0;
                prev_sload[d] <= 1'b0;
            end else begin
                prev_sclk[d]  <= sclk_w[d];
                prev_sload[d] <= sload_w[d];
                if (sclk_w[d] && !prev_sclk[d]) begin
                    sh0[d]    <= {sh0[d][6:0], sdata_w[d][0]};
                    sh1[d]    <= {sh1[d][6:0], sdata_w[d][1]};
                    bitcnt[d] <= bitcnt[d] + 1;
                end
                if (sload_w[d] && !prev_sload[d]) begin
                    if (bitcnt[d] == 8 && frame_cnt[d] < 16) begin
                        frames[d][frame_cnt[d]] <= {sh1[d], sh0[d]};
                        frame_cnt[d]            <= frame_cnt[d] + 1;
                    end
                    bitcnt[d] <= 0;
                end
            end
            if (busy_w[d]) begin
                busy_run[d] <= busy_run[d] + 1;
            end else begin
                if (busy_run[d] != 0) busy_len[d] <= busy_run[d];
                busy_run[d] <= 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int d);
        upd[d] = 1'b1;
        @(negedge clk);
        upd[d] = 1'b0;
    endtask

    task automatic wait_frames(input int d, input int target, input int bound);
        int n;
        n = 0;
        while (frame_cnt[d] < target && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("frame_wait", 32'(frame_cnt[d] >= target), 32'd1);
    endtask

    task automatic chk_reset_outputs(input int d);
        chk("rst_sclk",   32'(sclk_w[d]),   32'd0);
        chk("rst_sdata",  32'(sdata_w[d]),  32'd0);
        chk("rst_sload",  32'(sload_w[d]),  32'd0);
        chk("rst_sclr_n", 32'(sclr_n_w[d]), 32'd0);
        chk("rst_soe_n",  32'(soe_n_w[d]),  32'd1);
        chk("rst_busy",   32'(busy_w[d]),   32'd1);
    endtask

    initial begin
        int lows;
        int n;
        for (int d = 0; d < 2; d++) begin
            bits[d]   = 16'h0000;
            bright[d] = 8'd128;
            upd[d]    = 1'b0;
        end
        rst = 1'b1;
        idle_cycles(3);

        // Reset state, then the clear/latch-zeros sequence with outputs disabled.
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        rst = 1'b0;
        @(negedge clk);
        chk("clr1_sclr_n", 32'(sclr_n_w[0]), 32'd0);
        chk("clr1_sload",  32'(sload_w[0]),  32'd0);
        chk("clr1_soe_n",  32'(soe_n_w[0]),  32'd1);
        @(negedge clk);
        chk("ld1_sclr_n",  32'(sclr_n_w[0]), 32'd1);
        chk("ld1_sload",   32'(sload_w[0]),  32'd1);
        chk("ld1_soe_n",   32'(soe_n_w[0]),  32'd1);
        @(negedge clk);
        chk("ld2_sload",   32'(sload_w[0]),  32'd1);
        chk("ld2_soe_n",   32'(soe_n_w[0]),  32'd1);
        @(negedge clk);
        chk("idle_sload",  32'(sload_w[0]),  32'd0);
        chk("idle_busy",   32'(busy_w[0]),   32'd0);
        chk("idle_soe_n",  32'(soe_n_w[0]),  32'd0);
        @(negedge clk);
        chk("auto_busy",   32'(busy_w[0]),   32'd1);

        // Power-up frame of zeros from the pending flag.
        wait_frames(0, 1, 300);
        wait_frames(1, 1, 300);
        idle_cycles(20);
        chk("pwrup_a_data", 32'(frames[0][0]), 32'h0000);
        chk("pwrup_b_data", 32'(frames[1][0]), 32'h0000);
        chk("pwrup_busy_len", 32'(busy_len[0]), 32'd34);

        // MSB-first frame: busy rises right after the request, lasts 34 cycles.
        bits[0] = 16'hA55A;
        pulse(0);
        chk("a55a_busy_rise", 32'(busy_w[0]), 32'd1);
        wait_frames(0, 2, 300);
        idle_cycles(60);
        chk("a55a_data",     32'(frames[0][1]), 32'hA55A);
        chk("a55a_busy_len", 32'(busy_len[0]),  32'd34);
        chk("a55a_count",    32'(frame_cnt[0]), 32'd2);

        // Image change mid-frame: old snapshot now, exactly one refresh after.
        bits[0] = 16'h12F0;
        idle_cycles(10);
        bits[0] = 16'h0F3C;
        wait_frames(0, 4, 400);
        idle_cycles(80);
        chk("mid_old",   32'(frames[0][2]), 32'h12F0);
        chk("mid_new",   32'(frames[0][3]), 32'h0F3C);
        chk("mid_count", 32'(frame_cnt[0]), 32'd4);

        // LSB-first instance: first bit shifted is bit 0, so captures are bit-reversed.
        bits[1] = 16'h12F0;
        pulse(1);
        chk("lsb_busy_rise", 32'(busy_w[1]), 32'd1);
        wait_frames(1, 2, 300);
        idle_cycles(60);
        chk("lsb_12f0", 32'(frames[1][1]), 32'h480F);
        bits[1] = 16'hA55A;
        pulse(1);
        wait_frames(1, 3, 300);
        idle_cycles(60);
        chk("lsb_a55a", 32'(frames[1][2]), 32'hA55A);

        // Three requests while busy coalesce into one extra frame.
        bits[1] = 16'h8001;
        pulse(1);
        idle_cycles(5);
        pulse(1);
        idle_cycles(3);
        pulse(1);
        idle_cycles(3);
        pulse(1);
        wait_frames(1, 5, 400);
        idle_cycles(100);
        chk("coal_count",  32'(frame_cnt[1]), 32'd5);
        chk("coal_first",  32'(frames[1][3]), 32'h0180);
        chk("coal_second", 32'(frames[1][4]), 32'h0180);
        chk("coal_busy_len", 32'(busy_len[1]), 32'd34);

        // Without auto refresh an image change alone sends nothing.
        bits[1] = 16'h5555;
        idle_cycles(60);
        chk("noauto_count", 32'(frame_cnt[1]), 32'd5);

        // PWM duty over one full 256-cycle counter period.
        bright[0] = 8'd0;
        lows = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (!soe_n_w[0]) lows++;
        end
        chk("pwm_0", 32'(lows), 32'd0);
        bright[0] = 8'd64;
        lows = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (!soe_n_w[0]) lows++;
        end
        chk("pwm_64", 32'(lows), 32'd64);
        bright[0] = 8'd255;
        lows = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (!soe_n_w[0]) lows++;
        end
        chk("pwm_255", 32'(lows), 32'd255);
        bright[0] = 8'd128;

        // Reset during bit 3 of a frame abandons it and replays the clear sequence.
        bits[0] = 16'hC3E1;
        n = 0;
        while (bitcnt[0] != 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("bit3_reached", 32'(bitcnt[0]), 32'd3);
        chk("bit3_busy",    32'(busy_w[0]),  32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs(0);
        rst = 1'b0;
        @(negedge clk);
        chk("reclr_sclr_n", 32'(sclr_n_w[0]), 32'd0);
        @(negedge clk);
        chk("reld_sclr_n",  32'(sclr_n_w[0]), 32'd1);
        chk("reld_sload",   32'(sload_w[0]),  32'd1);
        wait_frames(0, 5, 300);
        idle_cycles(50);
        chk("rerun_data",  32'(frames[0][4]), 32'hC3E1);
        chk("rerun_count", 32'(frame_cnt[0]), 32'd5);
        chk("rerun_busy_len", 32'(busy_len[0]), 32'd34);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
